imem_loader: RTL

- Host-side program loader for the pipelined CPU.
- Receives a length-prefixed, checksummed byte stream over a valid/ready interface.
- Zero-fills instruction memory, then writes the assembled 32-bit instructions into it.
- Releases the CPU by asserting start_o only after a verified load.

---
 rtl/imem_loader.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory after zero-filling it, then releases the CPU.
// Latency: a word write appears the cycle after its 4th byte; start_o rises the cycle after a matching checksum byte.
// Backpressure: rx_ready_o depends on state only; it is low during CLEAR, RUN, ERR and IDLE, and load_i drops a coincident byte.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              start_o,
    output logic              busy_o,
    output logic [1:0]        err_o,
    output logic [ADDR_W:0]   words_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [16:0]       DEPTH_L  = 17'(DEPTH);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WORD_ONE = (ADDR_W+1)'(1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [7:0]        len_lo_q;
    logic [ADDR_W:0]   len_q;
    logic [1:0]        byte_idx_q;
    logic [23:0]       byte_buf_q;
    logic [7:0]        csum_q;

    logic              restart;
    logic              hs;
    logic [15:0]       len_full;
    logic              len_bad;
    logic              clr_last;
    logic              word_done;
    logic              last_word;
    logic              csum_ok;

    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       data_d;
    logic              start_d;
    logic              busy_d;
    logic [1:0]        err_d;
    logic [ADDR_W:0]   words_d;

    // A load request restarts from any state except CLEAR; it also masks a coincident byte.
    assign restart   = load_i && (state_q != S_CLEAR);
    assign hs        = rx_valid_i && rx_ready_o && !restart;
    assign len_full  = {rx_data_i, len_lo_q};
    assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > DEPTH_L);
    assign clr_last  = (clr_cnt_q == CLR_LAST);
    assign word_done = hs && (state_q == S_DATA) && (byte_idx_q == 2'd3);
    assign last_word = word_done && ((words_o + WORD_ONE) == len_q);
    assign csum_ok   = (rx_data_i == csum_q);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = S_CLEAR;
        end else begin
            case (state_q)
                S_CLEAR:  if (clr_last) state_d = S_LEN_LO;
                S_LEN_LO: if (hs) state_d = S_LEN_HI;
                S_LEN_HI: if (hs) state_d = len_bad ? S_ERR : S_DATA;
                S_DATA:   if (last_word) state_d = S_CHK;
                S_CHK:    if (hs) state_d = csum_ok ? S_RUN : S_ERR;
                default:  state_d = state_q;
            endcase
        end
    end

    // Output decode: combinational ready plus next values of the registered outputs.
    always_comb begin
        rx_ready_o = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_DATA)   || (state_q == S_CHK);
        we_d    = 1'b0;
        addr_d  = imem_addr_o;
        data_d  = imem_data_o;
        err_d   = err_o;
        words_d = words_o;
        if (restart) begin
            we_d    = 1'b1;
            addr_d  = '0;
            data_d  = '0;
            err_d   = 2'd0;
            words_d = '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    if (!clr_last) begin
                        we_d   = 1'b1;
                        addr_d = clr_cnt_q + ADDR_ONE;
                    end
                end
                S_LEN_HI: begin
                    if (hs && len_bad) err_d = 2'd1;
                end
                S_DATA: begin
                    if (word_done) begin
                        we_d    = 1'b1;
                        addr_d  = words_o[ADDR_W-1:0];
                        data_d  = {rx_data_i, byte_buf_q};
                        words_d = words_o + WORD_ONE;
                    end
                end
                S_CHK: begin
                    if (hs && !csum_ok) err_d = 2'd2;
                end
                default: ;
            endcase
        end
        start_d = (state_d == S_RUN);
        busy_d  = (state_d == S_CLEAR)  || (state_d == S_LEN_LO) ||
                  (state_d == S_LEN_HI) || (state_d == S_DATA)   ||
                  (state_d == S_CHK);
    end

    // Registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            imem_we_o   <= 1'b0;
            imem_addr_o <= '0;
            imem_data_o <= '0;
            start_o     <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 2'd0;
            words_o     <= '0;
        end else begin
            imem_we_o   <= we_d;
            imem_addr_o <= addr_d;
            imem_data_o <= data_d;
            start_o     <= start_d;
            busy_o      <= busy_d;
            err_o       <= err_d;
            words_o     <= words_d;
        end
    end

    // Clear counter, length capture, byte assembly and running checksum.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clr_cnt_q  <= '0;
            len_lo_q   <= '0;
            len_q      <= '0;
            byte_idx_q <= '0;
            byte_buf_q <= '0;
            csum_q     <= '0;
        end else if (restart) begin
            clr_cnt_q  <= '0;
            byte_idx_q <= '0;
            byte_buf_q <= '0;
            csum_q     <= '0;
        end else begin
            if ((state_q == S_CLEAR) && !clr_last) begin
                clr_cnt_q <= clr_cnt_q + ADDR_ONE;
            end
            if (hs && (state_q == S_LEN_LO)) begin
                len_lo_q <= rx_data_i;
            end
            if (hs && (state_q == S_LEN_HI)) begin
                len_q <= len_full[ADDR_W:0];
            end
            if (hs && (state_q == S_DATA)) begin
                csum_q     <= csum_q ^ rx_data_i;
                byte_idx_q <= byte_idx_q + 2'd1;
                case (byte_idx_q)
                    2'd0:    byte_buf_q[7:0]   <= rx_data_i;
                    2'd1:    byte_buf_q[15:8]  <= rx_data_i;
                    2'd2:    byte_buf_q[23:16] <= rx_data_i;
                    default: ;
                endcase
            end
        end
    end

endmodule
